// File: rtl/avalon_pio_gen2_pkg.sv
// Shared constants for the second-generation Avalon-MM PIO: register offsets,
// edge-capture modes and the widest supported port.
package pio_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIR          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR       = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/avalon_pio_gen2_if.sv
// Avalon-MM slave bus bundle for the PIO. Handshake: a write is taken in any
// cycle with chipselect=1 and write_n=0 (no waitrequest); readdata is valid in the same cycle as address.
interface avalon_pio_gen2_if;
  import pio_pkg::*;

  logic [2:0]           address;
  logic                 chipselect;
  logic                 write_n;
  logic [MAX_WIDTH-1:0] writedata;
  logic [MAX_WIDTH-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/avalon_pio_gen2_sync_edge.sv
// Input synchroniser, edge detector and post-reset priming for the PIO pins.
// Edges are held off until the chain has been refilled after reset.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [2:0]       r_prime;
  logic [WIDTH-1:0] w_raw;
  logic             w_primed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev  <= '0;
      r_prime <= '0;
    end else begin
      r_sync[0] <= i_pin;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      if (r_prime != PRIME_MAX) r_prime <= r_prime + 3'd1;
    end
  end

  assign o_sync   = r_sync[SYNC_STAGES-1];
  assign w_primed = (r_prime == PRIME_MAX);

  always_comb begin
    w_raw = o_sync & ~r_prev;
    case (EDGE_TYPE)
      EDGE_FALLING: w_raw = ~o_sync & r_prev;
      EDGE_ANY:     w_raw = o_sync ^ r_prev;
      default:      w_raw = o_sync & ~r_prev;
    endcase
  end

  // A pin held high through reset looks like a rising edge until prev catches up.
  assign o_edge = w_primed ? w_raw : '0;

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear, edge
// capture with write-1-clear and a maskable level interrupt.
module avalon_pio_gen2
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  avalon_pio_gen2_if.slave   bus,
  input  logic [WIDTH-1:0]   pio_in,
  output logic [WIDTH-1:0]   pio_out,
  output logic [WIDTH-1:0]   pio_oe,
  output logic               irq
);

  logic [WIDTH-1:0]     r_data_out;
  logic [WIDTH-1:0]     r_dir;
  logic [WIDTH-1:0]     r_irq_mask;
  logic [WIDTH-1:0]     r_edge_cap;

  logic                 w_wr;
  logic [WIDTH-1:0]     w_wdata;
  logic [WIDTH-1:0]     w_clr;
  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     w_edge;
  logic [MAX_WIDTH-1:0] w_rdata;
  logic                 w_unused_wdata;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pin   (pio_in),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_wdata        = bus.writedata[WIDTH-1:0];
  assign w_unused_wdata = ^bus.writedata;
  assign w_clr          = (w_wr && bus.address == ADDR_EDGE_CAPTURE) ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= OUT_RESET;
      r_dir      <= DIR_RESET;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
    end else begin
      // Set is OR-ed in after the clear so a coincident edge wins.
      r_edge_cap <= (r_edge_cap & ~w_clr) | (w_edge & ~r_dir);
      if (w_wr) begin
        case (bus.address)
          ADDR_DATA:     r_data_out <= w_wdata;
          ADDR_DIR:      r_dir      <= w_wdata;
          ADDR_IRQ_MASK: r_irq_mask <= w_wdata;
          ADDR_OUTSET:   r_data_out <= r_data_out | w_wdata;
          ADDR_OUTCLR:   r_data_out <= r_data_out & ~w_wdata;
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:         w_rdata[WIDTH-1:0] = (w_sync & ~r_dir) | (r_data_out & r_dir);
      ADDR_DIR:          w_rdata[WIDTH-1:0] = r_dir;
      ADDR_IRQ_MASK:     w_rdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAPTURE: w_rdata[WIDTH-1:0] = r_edge_cap;
      default:           w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;
  assign pio_out      = r_data_out;
  assign pio_oe       = r_dir;
  assign irq          = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Bench for avalon_pio_gen2: directed register/edge/reset scenarios followed by
// random bus and pin traffic, all checked every cycle against a pin-history model.
module tb_avalon_pio_gen2;
  import pio_pkg::*;

  localparam int               WIDTH       = 4;
  localparam int               SYNC_STAGES = 2;
  localparam int               EDGE_TYPE   = EDGE_RISING;
  localparam logic [WIDTH-1:0] OUT_RESET   = 4'hA;
  localparam logic [WIDTH-1:0] DIR_RESET   = 4'hF;

  // ---------------- clock / reset / DUT ----------------
  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] pio_in  = '0;
  logic [WIDTH-1:0] pio_out;
  logic [WIDTH-1:0] pio_oe;
  logic             irq;

  avalon_pio_gen2_if bus ();

  avalon_pio_gen2 #(
    .WIDTH       (WIDTH),
    .OUT_RESET   (OUT_RESET),
    .DIR_RESET   (DIR_RESET),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .pio_in  (pio_in),
    .pio_out (pio_out),
    .pio_oe  (pio_oe),
    .irq     (irq)
  );

  initial forever #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins seen at each rising edge since reset; the synchronised value is the pin
  // SYNC_STAGES edges old, and edges count only once SYNC_STAGES+1 edges have passed.
  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] m_dout = OUT_RESET;
  logic [WIDTH-1:0] m_dir  = DIR_RESET;
  logic [WIDTH-1:0] m_mask = '0;
  logic [WIDTH-1:0] m_cap  = '0;

  function automatic logic [WIDTH-1:0] pin_ago(input int d);
    int idx;
    idx = hist.size() - SYNC_STAGES - d;
    return (idx >= 0) ? hist[idx] : '0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    case (a)
      3'd0: v = (pin_ago(0) & ~m_dir) | (m_dout & m_dir);
      3'd1: v = m_dir;
      3'd2: v = m_mask;
      3'd3: v = m_cap;
      default: v = '0;
    endcase
    return 32'(v);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    logic [WIDTH-1:0] cur, prv, ev, wd;
    if (!reset_n) begin
      m_dout = OUT_RESET;
      m_dir  = DIR_RESET;
      m_mask = '0;
      m_cap  = '0;
      hist.delete();
    end else begin
      cur = pin_ago(0);
      prv = pin_ago(1);
      case (EDGE_TYPE)
        1:       ev = ~cur & prv;
        2:       ev = cur ^ prv;
        default: ev = cur & ~prv;
      endcase
      if (hist.size() < SYNC_STAGES + 1) ev = '0;
      ev = ev & ~m_dir;
      wd = bus.writedata[WIDTH-1:0];
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: m_dout = wd;
          3'd1: m_dir  = wd;
          3'd2: m_mask = wd;
          3'd3: m_cap  = m_cap & ~wd;
          3'd4: m_dout = m_dout | wd;
          3'd5: m_dout = m_dout & ~wd;
          default: ;
        endcase
      end
      m_cap = m_cap | ev;
      hist.push_back(pio_in);
    end
  end

  always @(negedge clk) begin
    #2;
    check("pio_out",  32'(pio_out), 32'(m_dout));
    check("pio_oe",   32'(pio_oe),  32'(m_dir));
    check("irq",      32'(irq),     32'(|(m_cap & m_mask)));
    check("readdata", bus.readdata, model_rd(bus.address));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    #1 bus.address = a;
    #1 d = bus.readdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0]      rd;
    logic [WIDTH-1:0] e;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;

    tick(3);
    reset_n = 1'b1;

    // reset values
    #1;
    check("rst_pio_out", 32'(pio_out), 32'h0000000A);
    check("rst_pio_oe",  32'(pio_oe),  32'h0000000F);
    check("rst_irq",     32'(irq),     32'h0);
    bus_read(3'd0, rd);
    check("rst_rd_data", rd, 32'h0000000A);

    // DATA / OUTSET / OUTCLR
    exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    exp_q.push_back(4'hC);
    bus_write(3'd0, 32'h5);
    #1 e = exp_q.pop_front(); check("wr_data", 32'(pio_out), 32'(e));
    bus_write(3'd4, 32'h8);
    #1 e = exp_q.pop_front(); check("outset", 32'(pio_out), 32'(e));
    bus_write(3'd5, 32'h1);
    #1 e = exp_q.pop_front(); check("outclr", 32'(pio_out), 32'(e));
    bus_read(3'd4, rd);
    check("rd_outset_zero", rd, 32'h0);
    bus_read(3'd5, rd);
    check("rd_outclr_zero", rd, 32'h0);

    // rising edge latency to irq, then write-1-clear
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    pio_in = 4'b0001;
    tick(SYNC_STAGES);
    #1 check("irq_before_latency", 32'(irq), 32'h0);
    tick(1);
    #1 check("irq_at_latency", 32'(irq), 32'h1);
    bus_read(3'd3, rd);
    check("cap_bit0", rd, 32'h1);
    bus_write(3'd3, 32'h1);
    #1 check("irq_after_clear", 32'(irq), 32'h0);

    // set wins over a coincident write-1-clear
    @(negedge clk) pio_in = 4'b0101;
    tick(4);
    @(negedge clk) pio_in = 4'b0001;
    tick(4);
    @(negedge clk) pio_in = 4'b0101;
    tick(SYNC_STAGES);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd3;
    bus.writedata  = 32'h4;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus_read(3'd3, rd);
    check("set_wins", rd, 32'h4);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, rd);
    check("clear_alone", rd, 32'h0);

    // pins high through reset: priming suppresses the false rising edge
    reset_n = 1'b0;
    pio_in  = 4'hF;
    tick(3);
    reset_n = 1'b1;
    bus_write(3'd1, 32'h0);
    tick(4);
    bus_read(3'd3, rd);
    check("no_prime_edge", rd, 32'h0);
    @(negedge clk) pio_in = 4'h0;
    tick(4);
    @(negedge clk) pio_in = 4'hF;
    tick(4);
    bus_read(3'd3, rd);
    check("edge_after_prime", rd, 32'hF);

    // outputs never capture; DATA mixes pins and data_out; async reset
    reset_n = 1'b0;
    pio_in  = 4'h0;
    tick(2);
    reset_n = 1'b1;
    bus_write(3'd1, 32'h3);
    bus_write(3'd2, 32'hF);
    @(negedge clk) pio_in = 4'b0100;
    tick(4);
    repeat (4) @(negedge clk) pio_in = pio_in ^ 4'b0011;
    tick(4);
    bus_read(3'd3, rd);
    check("out_no_capture", rd, 32'h4);
    bus_read(3'd0, rd);
    check("data_mixed", rd, 32'h6);
    #1 check("irq_before_rst", 32'(irq), 32'h1);
    @(negedge clk) pio_in = pio_in ^ 4'b0011;
    #3 reset_n = 1'b0;
    bus.address = 3'd2;
    #1;
    check("async_rst_pio_out", 32'(pio_out), 32'h0000000A);
    check("async_rst_pio_oe",  32'(pio_oe),  32'h0000000F);
    check("async_rst_irq",     32'(irq),     32'h0);
    check("async_rst_mask",    bus.readdata, 32'h0);
    tick(2);
    reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      pio_in         = pio_in ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      bus.chipselect = ($urandom_range(0, 2) == 0);
      bus.write_n    = 1'($urandom_range(0, 1));
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = $urandom();
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    tick(2);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
